transcript_reader: RTL and testbench
====================================

Name: transcript_reader

Overview:
- Downstream drain stage for the two 16x8 transcript memories that hold ALU results.
- On a start pulse, reads transcript memory 1 entries 0..tm1_count-1, then transcript memory 2 entries 0..tm2_count-1, through each memory's read port B.
- Emits each result as one beat on a valid/ready stream, tagged with source memory and address, for the host/UART side to consume.

Parameters:
- READ_LATENCY, 1: port-B read latency in cycles from RENB/ADDRB to DOUTB. Legal values are 1 or 2.
- FIFO_DEPTH, 4: output buffer entries. Must be >= READ_LATENCY+1 for full throughput; elaboration error if smaller.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a drain.
- tm1_count  in  5  number of valid entries in memory 1 (0..16). Sampled on accepted start.
- tm2_count  in  5  number of valid entries in memory 2 (0..16). Sampled on accepted start.
- Trans_Mem1_ADDRB  out  4  memory 1 read address.
- Trans_Mem1_RENB  out  1  memory 1 read enable.
- Trans_Mem1_DOUTB  in  8  memory 1 read data.
- Trans_Mem2_ADDRB  out  4  memory 2 read address.
- Trans_Mem2_RENB  out  1  memory 2 read enable.
- Trans_Mem2_DOUTB  in  8  memory 2 read data.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  consumer ready.
- out_data  out  8  ALU result.
- out_src  out  1  0 = memory 1, 1 = memory 2.
- out_addr  out  4  address the result was read from.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset (reset=0, async): FSM to IDLE; all RENB=0, ADDRB=0, out_valid=0, out_data/out_src/out_addr=0, busy=0, done=0. FIFO emptied, in-flight reads discarded. Applies mid-drain too; no beat is emitted after reset deasserts unless a new start arrives.
- States: IDLE, RD1, RD2, DRAIN, FIN.
- IDLE: start=1 latches the counts (values >16 saturate to 16), sets busy=1 next cycle, and moves to RD1. If tm1_count=0, go to RD2 instead; if both counts are 0, go directly to FIN.
- start while busy is ignored; latched counts are unchanged.
- RD1/RD2 issue one read per cycle at the current address while issue_ok holds.
  - issue_ok = (fifo_occupancy + inflight - pop_this_cycle) < FIFO_DEPTH.
  - RENB is high only in cycles that issue; ADDRB holds its last value otherwise.
  - Only one memory's RENB is high in any cycle.
- Address counter increments on each issue and resets to 0 at the RD1->RD2 transition.
- RD1 -> RD2 after issuing address tm1_count-1. If tm2_count=0, go to DRAIN instead.
- RD2 -> DRAIN after issuing address tm2_count-1.
- Read data return: a READ_LATENCY-deep shift register of {valid, src, addr} travels with each issue. When it exits, DOUTB of the tagged memory is pushed into the FIFO in that cycle. Pushes never overflow because of issue_ok.
- Output: FIFO head drives out_*. A beat transfers when out_valid && out_ready.
  - out_data/out_src/out_addr are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
- Throughput: with out_ready held at 1, one beat per cycle after the initial READ_LATENCY+1 cycle fill.
- DRAIN -> FIN when inflight=0 and the FIFO is empty.
- FIN: done=1 for one cycle, busy=0 the same cycle, then return to IDLE. A start in the FIN cycle is ignored.
- Beat order is strictly memory 1 ascending, then memory 2 ascending.

Decomposition:
- Package transcript_pkg holds:
  - DATA_W=8, ADDR_W=4, MEM_DEPTH=16, CNT_W=5;
  - typedef enum state_t {IDLE, RD1, RD2, DRAIN, FIN};
  - packed struct beat_t {src, addr, data}.
- Sub-module result_fifo is a synchronous FIFO of beat_t. It has parameter DEPTH, push/pop/full/empty/count, and allows simultaneous push and pop when full or empty as a legal pass-through. Its reset is async active-low.

Test Plan:
- Memory models with READ_LATENCY=1. mem1[i]=0x10+i, mem2[i]=0x80+i, tm1_count=3, tm2_count=2, out_ready=1 -> beats in order (0,0,0x10),(0,1,0x11),(0,2,0x12),(1,0,0x80),(1,1,0x81); done pulses once; busy is high for exactly the drain.
- tm1_count=0, tm2_count=16 -> Trans_Mem1_RENB never asserts; 16 beats with src=1, addresses 0..15; then done.
- Both counts 0 -> no RENB and no out_valid; done pulses within 3 cycles of start.
- Counts 4/4, out_ready toggling 1,0,0,1 repeatedly -> no beat lost or duplicated; fields stable while stalled; inflight+occupancy never exceeds 4.
- READ_LATENCY=2, FIFO_DEPTH=3, counts 16/16, out_ready=1 -> 32 beats, one per cycle after the initial fill.
- Assert reset for 1 cycle after the 5th beat of a 10/10 drain -> all outputs zero immediately. No further beats appear; a new start with counts 2/0 yields exactly 2 beats from address 0.

Source files
------------

// File: rtl/transcript_pkg.sv
// transcript_pkg: shared widths, FSM states and the stream beat record for the transcript drain.
package transcript_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int MEM_DEPTH = 16;
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {IDLE, RD1, RD2, DRAIN, FIN} state_t;

    typedef struct packed {
        logic src;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } beat_t;

    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(MEM_DEPTH)) ? CNT_W'(MEM_DEPTH) : c;
    endfunction
endpackage

// File: rtl/transcript_reader_result_fifo.sv
// result_fifo: synchronous beat FIFO; push with pop is accepted when full.
module result_fifo
    import transcript_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  beat_t         din,
    input  logic          pop,
    output beat_t         dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    beat_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/transcript_reader.sv
// transcript_reader: drains transcript memories 1 then 2 through port B into a valid/ready stream.
module transcript_reader
    import transcript_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  tm1_count,
    input  logic [CNT_W-1:0]  tm2_count,
    output logic [ADDR_W-1:0] Trans_Mem1_ADDRB,
    output logic              Trans_Mem1_RENB,
    input  logic [DATA_W-1:0] Trans_Mem1_DOUTB,
    output logic [ADDR_W-1:0] Trans_Mem2_ADDRB,
    output logic              Trans_Mem2_RENB,
    input  logic [DATA_W-1:0] Trans_Mem2_DOUTB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = FCW + 2;

    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
        $error("transcript_reader: READ_LATENCY must be 1 or 2");
    end
    if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
        $error("transcript_reader: FIFO_DEPTH must be at least READ_LATENCY+1");
    end

    state_t state;
    logic [CNT_W-1:0] cnt1, cnt2, s1, s2;
    logic [ADDR_W-1:0] addr, last1, last2;
    logic [READ_LATENCY-1:0] p_valid, p_src;
    logic [READ_LATENCY-1:0][ADDR_W-1:0] p_addr;
    logic [FCW-1:0] occ;
    logic [OW-1:0] pending;
    logic fifo_empty, fifo_full, pop, push, issue, issue_ok, last_issue;
    beat_t head, wbeat;

    assign s1 = sat_count(tm1_count);
    assign s2 = sat_count(tm2_count);
    assign pop = out_valid && out_ready;
    // Reserve a FIFO slot for every read still travelling through the latency pipe.
    assign pending = OW'(occ) + OW'($countones(p_valid)) - OW'(pop);
    assign issue_ok = pending < OW'(FIFO_DEPTH);
    assign issue = (state == RD1 || state == RD2) && issue_ok;
    assign last_issue = CNT_W'(addr) + CNT_W'(1) == ((state == RD1) ? cnt1 : cnt2);

    assign Trans_Mem1_RENB = issue && state == RD1;
    assign Trans_Mem2_RENB = issue && state == RD2;
    assign Trans_Mem1_ADDRB = Trans_Mem1_RENB ? addr : last1;
    assign Trans_Mem2_ADDRB = Trans_Mem2_RENB ? addr : last2;
    assign busy = state inside {RD1, RD2, DRAIN};
    assign done = state == FIN;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt1 <= '0;
            cnt2 <= '0;
            addr <= '0;
            last1 <= '0;
            last2 <= '0;
        end else begin
            if (Trans_Mem1_RENB) last1 <= addr;
            if (Trans_Mem2_RENB) last2 <= addr;
            if (issue) addr <= last_issue ? '0 : addr + ADDR_W'(1);
            case (state)
                IDLE: if (start) begin
                    cnt1 <= s1;
                    cnt2 <= s2;
                    addr <= '0;
                    state <= (s1 != '0) ? RD1 : (s2 != '0) ? RD2 : FIN;
                end
                RD1: if (issue && last_issue) state <= (cnt2 != '0) ? RD2 : DRAIN;
                RD2: if (issue && last_issue) state <= DRAIN;
                DRAIN: if (p_valid == '0 && fifo_empty) state <= FIN;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_valid <= '0;
            p_src <= '0;
            p_addr <= '0;
        end else begin
            p_valid[0] <= issue;
            p_src[0] <= state == RD2;
            p_addr[0] <= addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                p_valid[i] <= p_valid[i-1];
                p_src[i] <= p_src[i-1];
                p_addr[i] <= p_addr[i-1];
            end
        end
    end

    assign push = p_valid[READ_LATENCY-1];
    assign wbeat = '{src: p_src[READ_LATENCY-1], addr: p_addr[READ_LATENCY-1],
                     data: p_src[READ_LATENCY-1] ? Trans_Mem2_DOUTB : Trans_Mem1_DOUTB};

    result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .din(wbeat),
        .pop(pop),
        .dout(head),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(occ)
    );

    assert property (@(posedge clock) disable iff (!reset) !(push && fifo_full && !pop));

    assign out_valid = !fifo_empty;
    assign out_data = fifo_empty ? '0 : head.data;
    assign out_src = fifo_empty ? 1'b0 : head.src;
    assign out_addr = fifo_empty ? '0 : head.addr;
endmodule

// File: tb/tb_transcript_reader.sv
// tb_transcript_reader: two instances (latency 1/depth 4, latency 2/depth 3) checked against a beat-order model.
module tb_transcript_reader;
    import transcript_pkg::*;

    logic clock = 0;
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic reset;
    logic start [2];
    logic [4:0] tm1 [2], tm2 [2];
    logic [3:0] a1 [2], a2 [2], oaddr [2];
    logic r1 [2], r2 [2], ov [2], ordy [2], osrc [2], bsy [2], dn [2];
    logic [7:0] odata [2];
    logic [7:0] mem1 [2][16], mem2 [2][16];

    int rmode [2] = '{0, 0};
    logic [12:0] exp_q [2][64];
    int beat_cyc [2][64];
    int eh [2] = '{0, 0}, en [2] = '{0, 0};
    int n_r1 [2] = '{0, 0}, n_r2 [2] = '{0, 0}, n_both [2] = '{0, 0};
    int n_busy [2] = '{0, 0}, n_done [2] = '{0, 0}, n_beat [2] = '{0, 0};
    int checks = 0, errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [7:0] m1a, m1b, m2a, m2b, dout1, dout2;
        always @(posedge clock) begin
            if (r1[g]) m1a <= mem1[g][a1[g]];
            if (r2[g]) m2a <= mem2[g][a2[g]];
            m1b <= m1a;
            m2b <= m2a;
        end
        assign dout1 = (g == 0) ? m1a : m1b;
        assign dout2 = (g == 0) ? m2a : m2b;
        transcript_reader #(.READ_LATENCY(g + 1), .FIFO_DEPTH(g == 0 ? 4 : 3)) dut (
            .clock(clock), .reset(reset), .start(start[g]),
            .tm1_count(tm1[g]), .tm2_count(tm2[g]),
            .Trans_Mem1_ADDRB(a1[g]), .Trans_Mem1_RENB(r1[g]), .Trans_Mem1_DOUTB(dout1),
            .Trans_Mem2_ADDRB(a2[g]), .Trans_Mem2_RENB(r2[g]), .Trans_Mem2_DOUTB(dout2),
            .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(odata[g]),
            .out_src(osrc[g]), .out_addr(oaddr[g]), .busy(bsy[g]), .done(dn[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, want, cyc);
        end
    endtask

    function automatic logic [25:0] outs(input int g);
        return {ov[g], r1[g], r2[g], a1[g], a2[g], odata[g], osrc[g], oaddr[g], bsy[g], dn[g]};
    endfunction

    task automatic set_mem(input int g, input bit fixed);
        for (int i = 0; i < 16; i++) begin
            mem1[g][i] = fixed ? 8'(8'h10 + i) : 8'($urandom);
            mem2[g][i] = fixed ? 8'(8'h80 + i) : 8'($urandom);
        end
    endtask

    task automatic expect_beats(input int g, input int s1, input int s2);
        for (int i = 0; i < s1; i++) begin
            exp_q[g][en[g] % 64] = {1'b0, 4'(i), mem1[g][i]};
            en[g]++;
        end
        for (int i = 0; i < s2; i++) begin
            exp_q[g][en[g] % 64] = {1'b1, 4'(i), mem2[g][i]};
            en[g]++;
        end
    endtask

    task automatic pulse_start(input int g, input logic [4:0] c1, input logic [4:0] c2);
        @(posedge clock); #1;
        tm1[g] = c1;
        tm2[g] = c2;
        start[g] = 1;
        @(posedge clock); #1;
        start[g] = 0;
        tm1[g] = 5'($urandom);
        tm2[g] = 5'($urandom);
    endtask

    // poke 1: start during the done cycle; poke 2: start while busy.
    task automatic drain(input int g, input logic [4:0] c1, input logic [4:0] c2, input int mode, input int poke);
        int s1, s2, base, b_r1, b_r2, b_both, b_done, b_busy, t0, td;
        logic got;
        s1 = (c1 > 5'd16) ? 16 : int'(c1);
        s2 = (c2 > 5'd16) ? 16 : int'(c2);
        base = en[g];
        expect_beats(g, s1, s2);
        b_r1 = n_r1[g]; b_r2 = n_r2[g]; b_both = n_both[g];
        b_done = n_done[g]; b_busy = n_busy[g];
        rmode[g] = mode;
        pulse_start(g, c1, c2);
        t0 = cyc;
        @(negedge clock);
        check("busy_after_start", bsy[g], 32'(s1 + s2 > 0));
        got = dn[g];
        if (poke == 2) begin
            repeat (2) @(posedge clock);
            #1;
            check("busy_at_poke", bsy[g], 1);
            tm1[g] = 1; tm2[g] = 1; start[g] = 1;
            @(posedge clock); #1;
            start[g] = 0;
        end
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clock);
            got = dn[g];
        end
        td = cyc;
        check("done_seen", got, 1);
        check("busy_at_done", bsy[g], 0);
        if (s1 + s2 == 0) check("done_latency_ok", 32'(td - t0 <= 3), 1);
        if (poke == 1) begin
            tm1[g] = 1; tm2[g] = 1; start[g] = 1;
            @(posedge clock); #1;
            start[g] = 0;
            @(negedge clock);
            check("fin_start_ignored", {bsy[g], r1[g], r2[g]}, 0);
        end
        repeat (3) @(negedge clock);
        check("done_pulses", n_done[g] - b_done, 1);
        check("busy_cycles", n_busy[g] - b_busy, td - t0);
        check("mem1_reads", n_r1[g] - b_r1, s1);
        check("mem2_reads", n_r2[g] - b_r2, s2);
        check("both_renb", n_both[g] - b_both, 0);
        check("all_beats_seen", eh[g], en[g]);
        if (mode == 0 && s1 + s2 > 0 && eh[g] == en[g]) begin
            check("first_beat_latency", beat_cyc[g][base % 64] - t0, g + 2);
            check("beat_rate", beat_cyc[g][(en[g] - 1) % 64] - beat_cyc[g][base % 64], s1 + s2 - 1);
        end
    endtask

    task automatic reset_mid(input int g);
        int b, k;
        expect_beats(g, 10, 10);
        rmode[g] = 0;
        b = eh[g];
        pulse_start(g, 5'd10, 5'd10);
        for (k = 0; k < 100 && eh[g] - b < 5; k++) @(negedge clock);
        check("five_beats_before_reset", eh[g] - b, 5);
        @(posedge clock); #1;
        reset = 0;
        #1;
        check("outs_zero_in_reset", outs(g), 0);
        en[g] = eh[g];
        @(posedge clock); #1;
        reset = 1;
        b = n_beat[g];
        repeat (10) @(negedge clock);
        check("no_beat_after_reset", n_beat[g] - b, 0);
        drain(g, 5'd2, 5'd0, 0, 0);
    endtask

    initial begin
        int ph = 0;
        ordy[0] = 1;
        ordy[1] = 1;
        forever begin
            @(posedge clock); #1;
            ph++;
            for (int g = 0; g < 2; g++)
                ordy[g] = (rmode[g] == 0) ? 1'b1 : (rmode[g] == 1) ? (ph % 4 == 0 || ph % 4 == 3) : 1'($urandom);
        end
    end

    initial begin
        logic [25:0] held [2];
        bit stall_prev [2] = '{0, 0};
        forever begin
            @(negedge clock);
            for (int g = 0; g < 2; g++) begin
                if (!reset) stall_prev[g] = 0;
                else begin
                    if (r1[g]) n_r1[g]++;
                    if (r2[g]) n_r2[g]++;
                    if (r1[g] && r2[g]) n_both[g]++;
                    if (bsy[g]) n_busy[g]++;
                    if (dn[g]) n_done[g]++;
                    if (stall_prev[g]) check("held_while_stalled", {ov[g], osrc[g], oaddr[g], odata[g]}, held[g]);
                    if (ov[g] && ordy[g]) begin
                        n_beat[g]++;
                        check("beat_expected", 32'(eh[g] < en[g]), 1);
                        if (eh[g] < en[g]) begin
                            check("beat", {osrc[g], oaddr[g], odata[g]}, exp_q[g][eh[g] % 64]);
                            beat_cyc[g][eh[g] % 64] = cyc;
                            eh[g]++;
                        end
                    end
                    stall_prev[g] = ov[g] && !ordy[g];
                    held[g] = {1'b1, osrc[g], oaddr[g], odata[g]};
                end
            end
        end
    end

    initial begin
        reset = 0;
        for (int g = 0; g < 2; g++) begin
            start[g] = 0;
            tm1[g] = 0;
            tm2[g] = 0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int g = 0; g < 2; g++) check("reset_outputs", outs(g), 0);
        reset = 1;
        for (int g = 0; g < 2; g++) begin
            set_mem(g, 1);
            drain(g, 5'd3, 5'd2, 0, 0);
            set_mem(g, 0);
            drain(g, 5'd0, 5'd16, 0, 0);
            drain(g, 5'd0, 5'd0, 0, 1);
            drain(g, 5'd4, 5'd4, 1, 2);
            drain(g, 5'd16, 5'd16, 0, 0);
            drain(g, 5'd31, 5'd17, 0, 0);
            for (int i = 0; i < 6; i++) begin
                set_mem(g, 0);
                drain(g, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2, 0);
            end
            reset_mid(g);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
